// File: rtl/sc_regcounter_ctrl.sv
// Start/pause/clear sequencer emitting one-cycle clear and prescaled increment strobes for a counter.
// inc is combinational on current state/inputs; clear/state/done/busy are registered one cycle after commands.
module sc_regcounter_ctrl #(
  parameter int DATAWIDTH      = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      SC_CTRL_CLOCK_50,
  input  logic                      SC_CTRL_RESET_InLow,
  input  logic                      SC_CTRL_start_In,
  input  logic                      SC_CTRL_pause_In,
  input  logic                      SC_CTRL_clear_In,
  input  logic [PRESCALE_WIDTH-1:0] SC_CTRL_period_InBUS,
  input  logic [DATAWIDTH-1:0]      SC_CTRL_limit_InBUS,
  input  logic [DATAWIDTH-1:0]      SC_CTRL_count_InBUS,
  output logic                      SC_CTRL_inc_Out,
  output logic                      SC_CTRL_clear_Out,
  output logic                      SC_CTRL_done_Out,
  output logic                      SC_CTRL_busy_Out,
  output logic [1:0]                SC_CTRL_state_OutBUS
);

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'b00,
    STATE_RUN   = 2'b01,
    STATE_PAUSE = 2'b10,
    STATE_DONE  = 2'b11
  } stateType;

  stateType                  stateReg, stateNext;
  logic [PRESCALE_WIDTH-1:0] prescalerReg, prescalerNext;
  logic [PRESCALE_WIDTH-1:0] periodReg, periodNext;
  logic                      clearFlagReg, clearFlagNext;
  logic                      incComb;
  logic                      atLimit;
  logic                      tick;

  assign atLimit = (SC_CTRL_count_InBUS == SC_CTRL_limit_InBUS);
  assign tick    = (prescalerReg == '0);

  always_ff @(posedge SC_CTRL_CLOCK_50) begin
    if (!SC_CTRL_RESET_InLow) begin
      stateReg     <= STATE_IDLE;
      prescalerReg <= '0;
      periodReg    <= '0;
      clearFlagReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      prescalerReg <= prescalerNext;
      periodReg    <= periodNext;
      clearFlagReg <= clearFlagNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    prescalerNext = prescalerReg;
    periodNext    = periodReg;
    clearFlagNext = 1'b0;
    incComb       = 1'b0;
    if (SC_CTRL_clear_In) begin
      stateNext     = STATE_IDLE;
      clearFlagNext = 1'b1;
    end else begin
      case (stateReg)
        STATE_IDLE, STATE_DONE: begin
          if (SC_CTRL_start_In) begin
            stateNext     = STATE_RUN;
            periodNext    = SC_CTRL_period_InBUS;
            prescalerNext = SC_CTRL_period_InBUS;
            clearFlagNext = 1'b1;
          end
        end
        STATE_PAUSE: begin
          if (SC_CTRL_start_In) begin
            stateNext = STATE_RUN;
          end
        end
        STATE_RUN: begin
          // Pause freezes the prescaler so resume continues the same tick phase.
          if (SC_CTRL_pause_In) begin
            stateNext = STATE_PAUSE;
          end else begin
            prescalerNext = tick ? periodReg : prescalerReg - PRESCALE_WIDTH'(1);
            // While clear is pulsing the counter still shows its old value, so skip the compare.
            if (!clearFlagReg && atLimit) begin
              stateNext = STATE_DONE;
            end else if (tick && !clearFlagReg) begin
              incComb = 1'b1;
            end
          end
        end
        default: begin
          stateNext = STATE_IDLE;
        end
      endcase
    end
  end

  assign SC_CTRL_inc_Out      = incComb;
  assign SC_CTRL_clear_Out    = clearFlagReg;
  assign SC_CTRL_done_Out     = (stateReg == STATE_DONE);
  assign SC_CTRL_busy_Out     = (stateReg == STATE_RUN) || (stateReg == STATE_PAUSE);
  assign SC_CTRL_state_OutBUS = stateReg;

endmodule
